zstr_pipe: RTL and testbench
============================

Name: zstr_pipe

Overview:
- Parametrised multi-stage register pipeline for zbus valid/ack streams.
- Chains ST identical stages. Each stage has an optional forward-registered slice (breaks the vld/bus timing path) and an optional backward-registered skid slice (breaks the ack timing path).
- Adds a live occupancy count for debug and flow monitoring.
- Sits between zbus stream producers and consumers wherever long routes or clock-frequency pressure need pipelining without losing throughput.

Parameters:
- BW, 8: grouped bus width in bits; must be >=1.
- ST, 1: number of chained stages; must be >=1.
- RI, 1: 1 = each stage has a skid register, so zi_ack is driven from a flop; 0 = ack passes through combinationally.
- RO, 1: 1 = each stage has an output register, so zo_vld/zo_bus are driven from flops; 0 = vld/bus pass through.
- CW, derived: occupancy counter width = clog2(ST*(RI+RO)+1), minimum 1.

Ports:
- z_clk, input, 1: system clock.
- z_rst, input, 1: reset, asynchronous, active-high.
- zi_vld, input, 1: input transfer valid.
- zi_bus, input, BW: input grouped bus.
- zi_ack, output, 1: input transfer acknowledge.
- zo_vld, output, 1: output transfer valid.
- zo_bus, output, BW: output grouped bus.
- zo_ack, input, 1: output transfer acknowledge.
- cnt, output, CW: number of words currently held in the pipe.

Behaviour:
- Transfer rule: a transfer occurs on a port in any cycle with vld & ack both high at the z_clk rising edge.
- Producer rules: once vld is raised, bus is held stable until the transfer completes. Ack may depend combinationally on vld only where the stage mode allows it.
- Stage topology: stage k's output feeds stage k+1's input. Stage 0 input = zi_*. Stage ST-1 output = zo_*. Within a stage, the skid slice (RI) comes first, then the output slice (RO).
- Output slice (RO=1):
  - up_ack = dn_ack | ~o_vld.
  - If up_ack: o_vld <= up_vld.
  - If up_vld & up_ack: o_bus <= up_bus.
  - o_bus has no reset.
- Skid slice (RI=1):
  - up_ack = ~s_vld (registered).
  - Set s_vld and capture s_bus on up_vld & up_ack & ~dn_ack.
  - Clear s_vld on dn_ack.
  - dn_vld = up_vld | s_vld.
  - dn_bus = s_vld ? s_bus : up_bus.
- RI=0 / RO=0: the corresponding slice is a wire. With RI=RO=0 the whole block is combinational pass-through and cnt is constant 0.
- Latency: ST*RO cycles from zi transfer to zo_vld when downstream is idle. The skid slice adds no latency.
- Throughput: 1 word per cycle sustained in all modes.
- Capacity: ST*(RI+RO) words.
- Ordering: strict FIFO order. No word is dropped or duplicated under any ack pattern.
- Reset values (async, while z_rst high):
  - All o_vld and s_vld = 0.
  - zo_vld = 0; cnt = 0.
  - zi_ack = 1 when RI=1, or when RO=1 with the pipe empty.
  - Words presented during reset are discarded.
- Reset mid-operation: all held words are lost immediately. zo_vld deasserts asynchronously. After release the pipe behaves as freshly empty.
- cnt updates every cycle:
  - +1 on an input transfer.
  - -1 on an output transfer.
  - Unchanged when both or neither occur.
  - Never exceeds capacity; never wraps.
- Full: all stage registers hold valid words and zo_ack=0. zi_ack is then 0 (RI=1: registered; RI=0: combinational through the chain).
- Empty: zo_vld=0 and cnt=0.
- Combinational-path guarantees:
  - RI=1: no path from zo_ack to zi_ack.
  - RO=1: no path from zi_vld/zi_bus to zo_vld/zo_bus.

Test Plan:
- ST=2, RI=1, RO=1, zo_ack=1, stream 0x01..0x10 back-to-back -> zo sees 0x01..0x10 in order, first word 2 cycles after the first zi transfer, one word per cycle, cnt stays at 2.
- Same config, zo_ack=0 throughout, zi_vld=1 -> exactly 4 words accepted, then zi_ack=0 from a flop and cnt=4. Raise zo_ack -> words drain in order; cnt decrements 4,3,2,1,0 when no new input arrives.
- ST=1, RI=1, RO=1, random 50% zi_vld and 50% zo_ack over 1000 words -> scoreboard matches with no loss or duplicates. Check cnt against a model every cycle.
- ST=3, RI=0, RO=1 -> latency 3. Toggle zo_ack in the same cycle as zi_vld with the pipe full -> zi_ack follows zo_ack combinationally and cnt is unchanged on simultaneous in/out.
- RI=0, RO=0 -> zo_bus==zi_bus, zo_vld==zi_vld, zi_ack==zo_ack in the same cycle; cnt=0.
- Assert z_rst asynchronously with cnt=3 mid-stream -> zo_vld=0 and cnt=0 before the next edge. After release, a new stream 0xA0.. emerges with no stale words.

Source files
------------

// File: rtl/zstr_pipe_if.sv
// zbus valid/ack stream bundle: one word moves when vld and ack are both high at a clock edge.
// The master drives vld/bus and the slave answers with ack.
interface zstr_pipe_if #(
  parameter int BW = 8
);
  logic          vld;
  logic [BW-1:0] bus;
  logic          ack;

  modport master (output vld, output bus, input ack);
  modport slave  (input vld, input bus, output ack);
endinterface

// File: rtl/zstr_pipe.sv
// Multi-stage zbus stream pipeline: ST chained stages, each an optional skid slice (registered ack)
// followed by an optional output slice (registered vld/bus), plus a live word-occupancy count.
module zstr_pipe #(
  parameter  int BW  = 8,
  parameter  int ST  = 1,
  parameter  int RI  = 1,
  parameter  int RO  = 1,
  localparam int CAP = ST * (RI + RO),
  localparam int CW  = (CAP > 0) ? $clog2(CAP + 1) : 1
) (
  input  logic          z_clk,
  input  logic          z_rst,
  zstr_pipe_if.slave    zi,
  zstr_pipe_if.master   zo,
  output logic [CW-1:0] cnt
);

  // Element k is the boundary feeding stage k; element ST is the zo side.
  logic          vld_w [ST+1];
  logic [BW-1:0] bus_w [ST+1];
  logic          ack_w [ST+1];

  // Input valid is masked while in reset so words offered then are never taken.
  assign vld_w[0]  = zi.vld & ~z_rst;
  assign bus_w[0]  = zi.bus;
  assign zi.ack    = ack_w[0];
  assign zo.vld    = vld_w[ST];
  assign zo.bus    = bus_w[ST];
  assign ack_w[ST] = zo.ack;

  for (genvar k = 0; k < ST; k++) begin : g_stage
    logic          m_vld;
    logic [BW-1:0] m_bus;
    logic          m_ack;

    if (RI != 0) begin : g_skid
      logic          s_vld_q, s_vld_d;
      logic [BW-1:0] s_bus_q, s_bus_d;

      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      always_comb begin
        s_vld_d = s_vld_q;
        s_bus_d = s_bus_q;
        if (m_ack) begin
          s_vld_d = 1'b0;
        end else if (vld_w[k] && !s_vld_q) begin
          s_vld_d = 1'b1;
          s_bus_d = bus_w[k];
        end
      end

      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) s_vld_q <= 1'b0;
        else       s_vld_q <= s_vld_d;
      end

      // NOTE: data-only storage carries no reset; its valid flag alone says whether it is meaningful.
      always_ff @(posedge z_clk) begin
        s_bus_q <= s_bus_d;
      end

      assign ack_w[k] = ~s_vld_q;
      assign m_vld    = vld_w[k] | s_vld_q;
      assign m_bus    = s_vld_q ? s_bus_q : bus_w[k];
    end else begin : g_skid_wire
      assign ack_w[k] = m_ack;
      assign m_vld    = vld_w[k];
      assign m_bus    = bus_w[k];
    end

    if (RO != 0) begin : g_oreg
      logic          o_vld_q, o_vld_d;
      logic [BW-1:0] o_bus_q, o_bus_d;

      always_comb begin
        o_vld_d = o_vld_q;
        o_bus_d = o_bus_q;
        if (m_ack) begin
          o_vld_d = m_vld;
          if (m_vld) o_bus_d = m_bus;
        end
      end

      always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) o_vld_q <= 1'b0;
        else       o_vld_q <= o_vld_d;
      end

      always_ff @(posedge z_clk) begin
        o_bus_q <= o_bus_d;
      end

      assign m_ack      = ack_w[k+1] | ~o_vld_q;
      assign vld_w[k+1] = o_vld_q;
      assign bus_w[k+1] = o_bus_q;
    end else begin : g_oreg_wire
      assign m_ack      = ack_w[k+1];
      assign vld_w[k+1] = m_vld;
      assign bus_w[k+1] = m_bus;
    end
  end

  if (CAP > 0) begin : g_cnt
    logic          in_xfer, out_xfer;
    logic [CW-1:0] cnt_q, cnt_d;

    // Simultaneous in and out cancel; capacity is bounded by the stage flops so it cannot wrap.
    always_comb begin
      in_xfer  = vld_w[0] & ack_w[0];
      out_xfer = vld_w[ST] & ack_w[ST];
      cnt_d    = cnt_q;
      if (in_xfer && !out_xfer)      cnt_d = cnt_q + CW'(1);
      else if (!in_xfer && out_xfer) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge z_clk or posedge z_rst) begin
      if (z_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
  end else begin : g_no_cnt
    assign cnt = '0;
  end

endmodule

// File: tb/tb_zstr_pipe.sv
// Directed and scoreboarded checks of zstr_pipe across four configurations sharing one clock/reset:
// A ST=2 RI=1 RO=1, B ST=1 RI=1 RO=1, C ST=3 RI=0 RO=1, D ST=1 RI=0 RO=0.
module tb_zstr_pipe;

  logic z_clk = 1'b0;
  logic z_rst;
  always #5 z_clk = ~z_clk;

  zstr_pipe_if #(.BW(8)) a_in (), a_out ();
  zstr_pipe_if #(.BW(8)) b_in (), b_out ();
  zstr_pipe_if #(.BW(8)) c_in (), c_out ();
  zstr_pipe_if #(.BW(8)) d_in (), d_out ();

  logic [2:0] a_cnt;
  logic [1:0] b_cnt;
  logic [1:0] c_cnt;
  logic       d_cnt;

  zstr_pipe #(.BW(8), .ST(2), .RI(1), .RO(1)) u_a (
    .z_clk(z_clk), .z_rst(z_rst), .zi(a_in), .zo(a_out), .cnt(a_cnt));
  zstr_pipe #(.BW(8), .ST(1), .RI(1), .RO(1)) u_b (
    .z_clk(z_clk), .z_rst(z_rst), .zi(b_in), .zo(b_out), .cnt(b_cnt));
  zstr_pipe #(.BW(8), .ST(3), .RI(0), .RO(1)) u_c (
    .z_clk(z_clk), .z_rst(z_rst), .zi(c_in), .zo(c_out), .cnt(c_cnt));
  zstr_pipe #(.BW(8), .ST(1), .RI(0), .RO(0)) u_d (
    .z_clk(z_clk), .z_rst(z_rst), .zi(d_in), .zo(d_out), .cnt(d_cnt));

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic cyc();
    @(posedge z_clk);
    #1;
  endtask

  task automatic samp();
    @(negedge z_clk);
  endtask

  initial begin
    logic [7:0] word;
    logic [7:0] nxt;
    logic [7:0] sbq[$];
    logic [7:0] exp_w;
    bit         in_x, out_x;
    int         sent, rcvd, cnt_m, in_n, out_n;
    logic [7:0] d_bus_v [4] = '{8'h3c, 8'ha5, 8'h0f, 8'hff};
    logic       d_vld_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       d_ack_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    z_rst = 1'b1;
    a_in.vld = 1'b0; a_in.bus = '0; a_out.ack = 1'b0;
    b_in.vld = 1'b0; b_in.bus = '0; b_out.ack = 1'b0;
    c_in.vld = 1'b0; c_in.bus = '0; c_out.ack = 1'b0;
    d_in.vld = 1'b0; d_in.bus = '0; d_out.ack = 1'b0;

    // Reset state
    #12;
    check("rst_a_zo_vld", 32'(a_out.vld), 0);
    check("rst_a_cnt",    32'(a_cnt), 0);
    check("rst_a_zi_ack", 32'(a_in.ack), 1);
    check("rst_c_zi_ack", 32'(c_in.ack), 1);
    check("rst_c_cnt",    32'(c_cnt), 0);
    @(negedge z_clk);
    z_rst = 1'b0;

    // A: back-to-back stream 0x01..0x10 with zo_ack=1
    a_out.ack = 1'b1;
    for (int t = 0; t < 20; t++) begin
      cyc();
      a_in.vld = (t < 16);
      a_in.bus = 8'(t + 1);
      samp();
      in_n  = (t < 16) ? t : 16;
      out_n = (t < 2) ? 0 : ((t < 18) ? t - 2 : 16);
      check("t1_zi_ack", 32'(a_in.ack), 1);
      check("t1_zo_vld", 32'(a_out.vld), 32'(t >= 2 && t <= 17));
      if (t >= 2 && t <= 17) check("t1_zo_bus", 32'(a_out.bus), 32'(t - 1));
      check("t1_cnt", 32'(a_cnt), 32'(in_n - out_n));
    end

    // A: fill with zo_ack=0, exactly 4 words taken
    a_out.ack = 1'b0;
    word = 8'h21;
    for (int t = 0; t < 8; t++) begin
      cyc();
      a_in.vld = 1'b1;
      a_in.bus = word;
      samp();
      check("t2_zi_ack", 32'(a_in.ack), 32'(t < 4));
      check("t2_cnt", 32'(a_cnt), 32'((t < 4) ? t : 4));
      check("t2_zo_vld", 32'(a_out.vld), 32'(t >= 2));
      if (t >= 2) check("t2_zo_bus", 32'(a_out.bus), 32'h21);
      if (a_in.vld && a_in.ack) word = word + 8'd1;
    end
    check("t2_accepted", 32'(word - 8'h21), 4);

    // A: drain in order, cnt 4..0
    for (int d = 0; d < 5; d++) begin
      cyc();
      a_in.vld  = 1'b0;
      a_out.ack = 1'b1;
      samp();
      check("t2_drain_cnt", 32'(a_cnt), 32'(4 - d));
      check("t2_drain_vld", 32'(a_out.vld), 32'(d < 4));
      if (d < 4) check("t2_drain_bus", 32'(a_out.bus), 32'(8'h21 + 8'(d)));
    end

    // B: random valid/ack, scoreboard and count model
    sent = 0; rcvd = 0; cnt_m = 0; nxt = 8'h00; in_x = 1'b0;
    for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
      cyc();
      if (in_x || !b_in.vld) begin
        b_in.vld = (sent < 1000) && ($urandom_range(1, 0) == 1);
        b_in.bus = nxt;
      end
      b_out.ack = ($urandom_range(1, 0) == 1);
      samp();
      check("t3_cnt", 32'(b_cnt), 32'(cnt_m));
      check("t3_cap", 32'(b_cnt <= 2), 1);
      in_x  = b_in.vld && b_in.ack;
      out_x = b_out.vld && b_out.ack;
      if (out_x) begin
        if (sbq.size() == 0) begin
          check("t3_extra_word", 32'(sbq.size()), 1);
        end else begin
          exp_w = sbq.pop_front();
          check("t3_order", 32'(b_out.bus), 32'(exp_w));
        end
        rcvd++;
      end
      if (in_x) begin
        sbq.push_back(b_in.bus);
        sent++;
        nxt = nxt + 8'd1;
      end
      cnt_m = cnt_m + int'(in_x) - int'(out_x);
    end
    check("t3_words_out", 32'(rcvd), 1000);
    cyc();
    b_in.vld  = 1'b0;
    b_out.ack = 1'b0;

    // C: latency 3 with idle downstream
    c_out.ack = 1'b1;
    cyc(); c_in.vld = 1'b1; c_in.bus = 8'h55; samp();
    check("t4_lat_ack", 32'(c_in.ack), 1);
    cyc(); c_in.vld = 1'b0; samp();
    check("t4_lat_c1", 32'(c_out.vld), 0);
    cyc(); samp();
    check("t4_lat_c2", 32'(c_out.vld), 0);
    cyc(); samp();
    check("t4_lat_c3_vld", 32'(c_out.vld), 1);
    check("t4_lat_c3_bus", 32'(c_out.bus), 32'h55);
    cyc(); c_out.ack = 1'b0; samp();
    check("t4_empty_vld", 32'(c_out.vld), 0);
    check("t4_empty_cnt", 32'(c_cnt), 0);

    // C: fill to 3, then zi_ack follows zo_ack combinationally
    for (int i = 0; i < 3; i++) begin
      cyc(); c_in.vld = 1'b1; c_in.bus = 8'h61 + 8'(i); samp();
      check("t4_fill_ack", 32'(c_in.ack), 1);
    end
    cyc(); c_in.bus = 8'h64; samp();
    check("t4_full_ack", 32'(c_in.ack), 0);
    check("t4_full_cnt", 32'(c_cnt), 3);
    check("t4_full_bus", 32'(c_out.bus), 32'h61);
    c_out.ack = 1'b1; #1;
    check("t4_comb_hi", 32'(c_in.ack), 1);
    c_out.ack = 1'b0; #1;
    check("t4_comb_lo", 32'(c_in.ack), 0);
    c_out.ack = 1'b1; #1;
    check("t4_comb_hi2", 32'(c_in.ack), 1);
    cyc(); c_in.bus = 8'h65; samp();
    check("t4_both_cnt", 32'(c_cnt), 3);
    check("t4_both_bus", 32'(c_out.bus), 32'h62);
    cyc(); c_in.vld = 1'b0; samp();
    check("t4_both_cnt2", 32'(c_cnt), 3);
    check("t4_drain_63", 32'(c_out.bus), 32'h63);
    cyc(); samp();
    check("t4_drain_cnt2", 32'(c_cnt), 2);
    check("t4_drain_64", 32'(c_out.bus), 32'h64);
    cyc(); samp();
    check("t4_drain_cnt1", 32'(c_cnt), 1);
    check("t4_drain_65", 32'(c_out.bus), 32'h65);
    cyc(); samp();
    check("t4_drain_cnt0", 32'(c_cnt), 0);
    check("t4_drain_vld0", 32'(c_out.vld), 0);
    c_out.ack = 1'b0;

    // D: pure combinational pass-through
    for (int i = 0; i < 4; i++) begin
      cyc();
      d_in.vld  = d_vld_v[i];
      d_in.bus  = d_bus_v[i];
      d_out.ack = d_ack_v[i];
      #1;
      check("t5_zo_vld", 32'(d_out.vld), 32'(d_vld_v[i]));
      check("t5_zo_bus", 32'(d_out.bus), 32'(d_bus_v[i]));
      check("t5_zi_ack", 32'(d_in.ack), 32'(d_ack_v[i]));
      check("t5_cnt", 32'(d_cnt), 0);
    end
    d_in.vld = 1'b0;

    // A: async reset with 3 words held, then fresh stream 0xA0..
    a_out.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); a_in.vld = 1'b1; a_in.bus = 8'h90 + 8'(i); samp();
    end
    cyc(); a_in.vld = 1'b0; samp();
    check("t6_pre_cnt", 32'(a_cnt), 3);
    check("t6_pre_vld", 32'(a_out.vld), 1);
    #1 z_rst = 1'b1;
    #1;
    check("t6_rst_vld", 32'(a_out.vld), 0);
    check("t6_rst_cnt", 32'(a_cnt), 0);
    check("t6_rst_ack", 32'(a_in.ack), 1);
    @(negedge z_clk);
    z_rst = 1'b0;
    a_out.ack = 1'b1;
    for (int t = 0; t < 7; t++) begin
      cyc();
      a_in.vld = (t < 4);
      a_in.bus = 8'ha0 + 8'(t);
      samp();
      check("t6_zo_vld", 32'(a_out.vld), 32'(t >= 2 && t < 6));
      if (t >= 2 && t < 6) check("t6_zo_bus", 32'(a_out.bus), 32'(8'ha0 + 8'(t - 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
